// File: rtl/fg_cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fg_cfg_pkg : default sizing and bank slicing helper for fg_cfg_bank      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fg_cfg_pkg;

   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_NUM_REGS    = 8;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_STRB_LEN    = 2;
   localparam int unsigned DEF_ADDR_W      = $clog2(DEF_NUM_REGS);

   // Register 0 lives in the MSBs of a flat bank.
   function automatic int unsigned reg_lsb(input int unsigned idx,
                                           input int unsigned nregs,
                                           input int unsigned dw);
      return (nregs - 1 - idx) * dw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fg_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fg_sync_edge : multi-stage synchronizer followed by a rising-edge pulse  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fg_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/fg_cfg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fg_cfg_bank : double-buffered config bank fed from async pads + DAC strobe|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fg_cfg_bank
   import fg_cfg_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
   parameter int unsigned ADDR_W      = $clog2(NUM_REGS),
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned SHADOW      = 1,
   parameter int unsigned STRB_LEN    = DEF_STRB_LEN
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_async_i,
   input  logic                       commit_async_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic [NUM_REGS*DATA_W-1:0] cfg_o,
   output logic                       cfg_update_o,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic                       wr_err_o,
   input  logic                       dac_valid_i,
   output logic                       dac_wr_n_o,
   output logic                       dac_clr_n_o,
   output logic                       dac_pd_n_o
);

   localparam int unsigned BANK_W = NUM_REGS * DATA_W;
   localparam int unsigned CNT_W  = $clog2(STRB_LEN + 1);

   logic              wr_pulse, commit_pulse;
   logic [BANK_W-1:0] shadow_q, shadow_d, active_q, active_d;
   logic [BANK_W-1:0] wbank, rbank;
   logic              hit;
   logic              upd_q, upd_d, err_q, err_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_n_q;

   fg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (wr_async_i),
      .pulse_o (wr_pulse)
   );

   fg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_commit_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (commit_async_i),
      .pulse_o (commit_pulse)
   );

   // The write is merged into wbank first so a same-cycle commit carries it.
   always_comb begin
      wbank = (SHADOW != 0) ? shadow_q : active_q;
      rbank = wbank;
      hit   = 1'b0;
      rd_d  = '0;
      for (int r = 0; r < int'(NUM_REGS); r++) begin
         if (addr_i == ADDR_W'(r)) begin
            hit  = 1'b1;
            rd_d = rbank[reg_lsb(r, NUM_REGS, DATA_W) +: DATA_W];
            if (wr_pulse) begin
               wbank[reg_lsb(r, NUM_REGS, DATA_W) +: DATA_W] = data_i;
            end
         end
      end

      shadow_d = shadow_q;
      active_d = active_q;
      upd_d    = 1'b0;
      if (SHADOW != 0) begin
         shadow_d = wbank;
         if (commit_pulse) begin
            active_d = wbank;
            upd_d    = 1'b1;
         end
      end else begin
         active_d = wbank;
         upd_d    = wr_pulse & hit;
      end
      err_d = wr_pulse & ~hit;

      if (dac_valid_i) begin
         cnt_d = CNT_W'(STRB_LEN);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         active_q <= '0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= '0;
         cnt_q    <= '0;
         wr_n_q   <= 1'b1;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         wr_n_q   <= (cnt_d == '0);
      end
   end

   assign cfg_o        = active_q;
   assign cfg_update_o = upd_q;
   assign rd_data_o    = rd_q;
   assign wr_err_o     = err_q;
   assign dac_wr_n_o   = wr_n_q;
   assign dac_clr_n_o  = ~rst_i;
   assign dac_pd_n_o   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_fg_cfg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fg_cfg_bank : self-checking bench for fg_cfg_bank (SHADOW=1, ADDR_W=4) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fg_cfg_bank;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int AW = 4;
   localparam int SS = 2;
   localparam int SL = 2;

   typedef logic [DW-1:0] bank_t [NR];

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          bad;
      int            hold;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wr = 1'b0, cm = 1'b0, dv = 1'b0;
   logic [AW-1:0]   addr = '0;
   logic [DW-1:0]   data = '0;
   logic [NR*DW-1:0] cfg;
   logic            upd, err, wr_n, clr_n, pd_n;
   logic [DW-1:0]   rd;

   int    checks = 0;
   int    errors = 0;
   bank_t m_sh, m_act;
   vec_t  vecs [6];
   vec_t  sb [$];

   fg_cfg_bank #(
      .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
      .SYNC_STAGES(SS), .SHADOW(1), .STRB_LEN(SL)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wr_async_i     (wr),
      .commit_async_i (cm),
      .addr_i         (addr),
      .data_i         (data),
      .cfg_o          (cfg),
      .cfg_update_o   (upd),
      .rd_data_o      (rd),
      .wr_err_o       (err),
      .dac_valid_i    (dv),
      .dac_wr_n_o     (wr_n),
      .dac_clr_n_o    (clr_n),
      .dac_pd_n_o     (pd_n)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   function automatic logic [NR*DW-1:0] flat(input bank_t b);
      logic [NR*DW-1:0] f;
      for (int r = 0; r < NR; r++) f[(NR-1-r)*DW +: DW] = b[r];
      return f;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Commit (optionally with a write raised on the same edge); cfg_o must switch at E2.
   task automatic do_commit(input logic with_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [NR*DW-1:0] prev;
      int nupd;
      prev = flat(m_act);
      nupd = 0;
      if (with_wr) begin
         addr = a; data = d; wr = 1'b1;
         m_sh[a[2:0]] = d;
      end
      cm = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         nupd += int'(upd);
         if (k == 2) check("cfg_before_E2", cfg, prev);
         if (k == 3) begin
            m_act = m_sh;
            check("cfg_at_E2", cfg, flat(m_act));
            check("upd_after_E2", upd, 1'b1);
         end
         if (k == 4) check("upd_one_cycle", upd, 1'b0);
      end
      cm = 1'b0; wr = 1'b0;
      repeat (SS + 2) begin tick(); nupd += int'(upd); end
      check("commit_upd_count", nupd, 1);
   endtask

   initial begin
      vec_t v, e;
      logic [DW-1:0] old, rd3, rd4;
      int nerr, nupd;
      logic exp_seq [4];

      vecs[0] = '{addr: 4'd3,  data: 8'hA5, bad: 1'b0, hold: 10};
      vecs[1] = '{addr: 4'd5,  data: 8'hA5, bad: 1'b0, hold: 5};
      vecs[2] = '{addr: 4'd0,  data: 8'h11, bad: 1'b0, hold: 5};
      vecs[3] = '{addr: 4'd7,  data: 8'h7E, bad: 1'b0, hold: 5};
      vecs[4] = '{addr: 4'd8,  data: 8'hFF, bad: 1'b1, hold: 5};
      vecs[5] = '{addr: 4'd15, data: 8'hC3, bad: 1'b1, hold: 5};
      for (int r = 0; r < NR; r++) begin m_sh[r] = '0; m_act[r] = '0; end

      // Reset state
      repeat (3) tick();
      check("rst_cfg", cfg, '0);
      check("rst_rd", rd, '0);
      check("rst_err", err, 1'b0);
      check("rst_upd", upd, 1'b0);
      check("rst_wr_n", wr_n, 1'b1);
      check("rst_clr_n", clr_n, 1'b0);
      check("pd_n", pd_n, 1'b1);
      rst = 1'b0;
      tick();
      check("clr_n_released", clr_n, 1'b1);

      // Table-driven writes into the shadow bank
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         sb.push_back(v);
         old = v.bad ? '0 : m_sh[v.addr[2:0]];
         addr = v.addr; data = v.data; wr = 1'b1;
         nerr = 0; nupd = 0; rd3 = '0; rd4 = '0;
         for (int k = 1; k <= v.hold; k++) begin
            tick();
            nerr += int'(err);
            nupd += int'(upd);
            if (k == 3) rd3 = rd;
            if (k == 4) rd4 = rd;
         end
         wr = 1'b0;
         repeat (SS + 2) begin tick(); nerr += int'(err); nupd += int'(upd); end
         e = sb.pop_front();
         check($sformatf("v%0d_err_count", i), nerr, e.bad ? 1 : 0);
         check($sformatf("v%0d_no_upd", i), nupd, 0);
         check($sformatf("v%0d_cfg_unchanged", i), cfg, flat(m_act));
         if (!e.bad) begin
            check($sformatf("v%0d_rd_before", i), rd3, old);
            check($sformatf("v%0d_rd_after", i), rd4, e.data);
            m_sh[e.addr[2:0]] = e.data;
         end
      end

      // Commit, then simultaneous write+commit
      do_commit(1'b0, '0, '0);
      check("reg3_active", cfg[(NR-1-3)*DW +: DW], 8'hA5);
      do_commit(1'b1, 4'd5, 8'h3C);
      check("reg5_merged", cfg[(NR-1-5)*DW +: DW], 8'h3C);

      // DAC strobe: single pulse, then back-to-back extension
      dv = 1'b1; tick(); dv = 1'b0;
      check("dac_T+1", wr_n, 1'b0);
      tick(); check("dac_T+2", wr_n, 1'b0);
      tick(); check("dac_T+3_idle", wr_n, 1'b1);
      repeat (2) tick();
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
      dv = 1'b1; tick();
      tick(); dv = 1'b0;
      check("dac_ext_0", wr_n, exp_seq[1]);
      for (int k = 2; k < 4; k++) begin
         tick();
         check($sformatf("dac_ext_%0d", k), wr_n, exp_seq[k]);
      end

      // Reset mid-synchronization and mid-pulse
      addr = 4'd2; data = 8'h55; wr = 1'b1; dv = 1'b1;
      tick(); dv = 1'b0;
      check("pre_rst_wr_n", wr_n, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_wr_n", wr_n, 1'b1);
      check("mid_rst_clr_n", clr_n, 1'b0);
      check("mid_rst_cfg", cfg, '0);
      check("mid_rst_rd", rd, '0);
      for (int r = 0; r < NR; r++) begin m_sh[r] = '0; m_act[r] = '0; end
      repeat (2) tick();
      #2 rst = 1'b0;
      nerr = 0; nupd = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         nerr += int'(err);
         nupd += int'(upd);
         if (k == 3) check("post_rst_rd_before", rd, '0);
         if (k == 4) check("post_rst_rd_after", rd, 8'h55);
      end
      wr = 1'b0;
      repeat (SS + 2) begin tick(); nerr += int'(err); nupd += int'(upd); end
      check("post_rst_no_err", nerr, 0);
      check("post_rst_no_upd", nupd, 0);
      check("post_rst_active_clear", cfg, '0);
      m_sh[2] = 8'h55;
      do_commit(1'b0, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fg_cfg_bank.md
# fg_cfg_bank

Parametrised configuration front-end for the function generator. It collects register writes from slow, asynchronous pad pins into a double-buffered register bank and presents the active bank as one flat bus to the generator core. It also turns the core's single-cycle output-valid strobe into a stretched, active-low DAC write pulse. It sits between the pad-level top and the function-generator core.

## Interface
Parameters:
- `DATA_W`, 8, width of each configuration register.
- `NUM_REGS`, 8, number of registers (≥2).
- `ADDR_W`, 3, address width; must satisfy 2^ADDR_W ≥ NUM_REGS.
- `SYNC_STAGES`, 2, flip-flop stages in each input synchronizer (≥2).
- `SHADOW`, 1, selects bank mode:
  - 1: writes land in the shadow bank; a commit copies shadow to active.
  - 0: writes go straight to the active bank.
- `STRB_LEN`, 2, DAC write pulse length in clocks (≥1).

Ports:
- `clk_i`, in, 1, system clock.
- `rst_i`, in, 1, reset; asynchronous, active-high.
- `wr_async_i`, in, 1, asynchronous write request; rising edge = one write.
- `commit_async_i`, in, 1, asynchronous commit request; rising edge = one commit. Ignored when SHADOW=0.
- `addr_i`, in, ADDR_W, register address; quasi-static.
- `data_i`, in, DATA_W, write data; quasi-static.
- `cfg_o`, out, NUM_REGS*DATA_W, active bank; register 0 occupies the MSBs.
- `cfg_update_o`, out, 1, one-cycle pulse on the clock after the active bank changes.
- `rd_data_o`, out, DATA_W, registered readback of shadow[addr_i] (active[addr_i] when SHADOW=0).
- `wr_err_o`, out, 1, one-cycle pulse when a write targets addr_i ≥ NUM_REGS.
- `dac_valid_i`, in, 1, core output-valid strobe; synchronous to clk_i.
- `dac_wr_n_o`, out, 1, DAC write, active low.
- `dac_clr_n_o`, out, 1, DAC clear, active low; equals !rst_i.
- `dac_pd_n_o`, out, 1, DAC power-down, active low; tied to 1.

## Operation
- Reset values:
  - Both banks, the sync/edge flops, rd_data_o, wr_err_o and cfg_update_o clear to 0.
  - The strobe counter clears to 0, so dac_wr_n_o=1.
  - dac_clr_n_o is 0 while rst_i=1.
- Each async input passes through a SYNC_STAGES synchronizer, then a rising-edge detector, giving a single-cycle internal pulse. A level held high produces exactly one event.
- Write event:
  - If addr_i < NUM_REGS, store data_i in the target register.
  - Otherwise nothing is stored and wr_err_o pulses for one cycle.
- Commit event (SHADOW=1): the active bank takes the entire shadow bank and cfg_update_o pulses.
- Write with SHADOW=0: the active register updates directly and cfg_update_o pulses.
- Write and commit edges in the same cycle: the write is merged first, so the active bank receives the newly written value.
- DAC strobe counter:
  - dac_valid_i=1 loads the counter with STRB_LEN.
  - Otherwise the counter decrements to 0.
  - dac_wr_n_o = !(counter≠0), registered.
  - A dac_valid_i arriving while a pulse is active reloads the counter, extending the pulse; no gap is inserted.
- Reset asserted mid-write or mid-pulse clears all state immediately. A request still high at release is treated as a fresh edge.

## Timing
- Edge numbering: E0 is the first clock edge that samples the async input high.
  - The edge pulse is high during the cycle after E(SYNC_STAGES−1).
  - The register updates at E(SYNC_STAGES); with the default, E2.
- addr_i and data_i must be stable from E0 through E(SYNC_STAGES).
- Commit: cfg_o changes at E(SYNC_STAGES); cfg_update_o is high for the following cycle.
- Readback: rd_data_o reflects a change of addr_i or of the bank one clock later.
- DAC strobe: dac_valid_i high at edge T gives dac_wr_n_o low for cycles T+1 … T+STRB_LEN.
- Minimum request spacing: the async request must stay low for ≥SYNC_STAGES+1 clocks between events.

## Structure
- Package `fg_cfg_pkg` holds:
  - the default localparams: DATA_W=8, NUM_REGS=8, SYNC_STAGES=2, STRB_LEN=2;
  - the ADDR_W derivation (clog2 of NUM_REGS).
- Sub-module `fg_sync_edge` (SYNC_STAGES synchronizer + rising-edge detector, active-high async reset) is instantiated twice: once for write, once for commit.
- Banks are flat vectors indexed by address; no array ports.

## Test plan
- Write data 0xA5 to address 3 with SHADOW=1, hold wr_async_i high 10 clocks:
  - shadow[3]=0xA5 at E2;
  - cfg_o unchanged;
  - exactly one write, with no cfg_update_o.
- Then pulse commit_async_i: cfg_o bits for register 3 read 0xA5 at E2, and cfg_update_o is high for one cycle.
- Raise write (addr 5, data 0x3C) and commit on the same edge: active[5]=0xA5→0x3C in a single update.
- Write to address 8 with NUM_REGS=8 (ADDR_W=4): one wr_err_o pulse; no bank bits change.
- DAC strobe with STRB_LEN=2:
  - dac_valid_i pulse at T gives dac_wr_n_o low at T+1 and T+2.
  - A second pulse at T+1 extends the low level through T+3.
- Assert rst_i mid-pulse and mid-synchronization:
  - dac_wr_n_o=1, dac_clr_n_o=0, both banks cleared, no spurious write.
  - After release with wr_async_i still high, exactly one write occurs at E2.
